// File: rtl/game_pkg.sv
// Shared game definitions: button-panel defaults and the one-hot helper
// functions used by both the button front end and the game-check logic.
package game_pkg;

    localparam int unsigned NUM_BTN_DEF         = 8;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned CNT_W_DEF           = 20;

    // Widest one-hot vector the helper functions accept.
    localparam int unsigned MAX_BTN = 32;
    localparam int unsigned MAX_IDX_W = $clog2(MAX_BTN);
    localparam int unsigned MAX_CNT_W = $clog2(MAX_BTN + 1);

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [MAX_IDX_W-1:0] lowest_set(input logic [MAX_BTN-1:0] v);
        lowest_set = '0;
        for (int i = MAX_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = MAX_IDX_W'(i);
            end
        end
    endfunction

    // Number of set bits.
    function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_BTN-1:0] v);
        popcount = '0;
        for (int i = 0; i < MAX_BTN; i++) begin
            popcount = popcount + MAX_CNT_W'(v[i]);
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button line: 2-flop synchronizer, stability counter and debounced level.
// rise pulses for one cycle right after the debounced level goes 0 -> 1.
// Optional BUTTON_CAPTURE_ACTIVE_LOW_EN: raw level is inverted before sync.
module btn_debounce
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    logic             raw_pressed;
    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

`ifdef BUTTON_CAPTURE_ACTIVE_LOW_EN
    assign raw_pressed = ~raw;
`else
    assign raw_pressed = raw;
`endif

    // Bring the asynchronous level into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw_pressed;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt    <= '0;
                stable <= sync_2;
                rise   <= sync_2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_capture.sv
// Player button panel front end: debounces every line and presents each clean
// press as a one-hot event over a valid/ready handshake with a one-entry buffer.
// Optional BUTTON_CAPTURE_ACTIVE_LOW_EN: buttons pull the raw line to ground.
module button_capture
    import game_pkg::*;
#(
    parameter int unsigned NUM_BTN         = NUM_BTN_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BTN-1:0]         btn_raw,
    input  logic                       press_ready,
    output logic                       press_valid,
    output logic [NUM_BTN-1:0]         press_onehot,
    output logic [$clog2(NUM_BTN)-1:0] press_index,
    output logic                       press_multi,
    output logic [NUM_BTN-1:0]         held,
    output logic                       overflow
);

    localparam int unsigned IDX_W = $clog2(NUM_BTN);

    logic [NUM_BTN-1:0] rise;
    logic [MAX_BTN-1:0] rise_wide;
    logic               any_rise;
    logic               drain;

    // One debouncer per button line.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[i]),
            .stable(held[i]),
            .rise  (rise[i])
        );
    end

    assign rise_wide = MAX_BTN'(rise);
    assign any_rise  = |rise;
    assign drain     = press_valid && press_ready;

    // Event buffer: load on a free or draining slot, otherwise drop and flag overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_valid  <= 1'b0;
            press_onehot <= '0;
            press_index  <= '0;
            press_multi  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (any_rise && (!press_valid || press_ready)) begin
                press_valid  <= 1'b1;
                press_onehot <= rise;
                press_index  <= IDX_W'(lowest_set(rise_wide));
                press_multi  <= (popcount(rise_wide) > MAX_CNT_W'(1));
            end else if (drain) begin
                press_valid <= 1'b0;
            end
            if (any_rise && press_valid && !press_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_capture.sv
// Randomized + directed bench for button_capture with a queue scoreboard.
module tb_button_capture;

    localparam int unsigned NB = 8;
    localparam int unsigned DC = 4;

`ifdef BUTTON_CAPTURE_ACTIVE_LOW_EN
    localparam logic [NB-1:0] INV_MASK = '1;
`else
    localparam logic [NB-1:0] INV_MASK = '0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] pressed;
    logic [NB-1:0] btn_raw;
    logic          press_ready;
    logic          press_valid;
    logic [NB-1:0] press_onehot;
    logic [2:0]    press_index;
    logic          press_multi;
    logic [NB-1:0] held;
    logic          overflow;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    assign btn_raw = pressed ^ INV_MASK;

    always #5 clk = ~clk;

    button_capture #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .press_ready (press_ready),
        .press_valid (press_valid),
        .press_onehot(press_onehot),
        .press_index (press_index),
        .press_multi (press_multi),
        .held        (held),
        .overflow    (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a press is accepted once the synchronized level has
    // disagreed with the accepted level for DC samples in a row; accepted
    // presses are offered to a one-slot buffer one cycle later.
    logic [NB-1:0] m_s1, m_s2, m_st, m_pend, m_new;
    int            m_run [NB];
    logic          m_valid, m_ovf;
    logic [NB-1:0] exp_q [$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_pend = '0;
            m_valid = 1'b0; m_ovf = 1'b0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
            exp_q.delete();
        end else begin
            if (m_pend != '0) begin
                if (!m_valid || press_ready) begin
                    exp_q.push_back(m_pend);
                    m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && press_ready) begin
                m_valid = 1'b0;
            end
            m_new = '0;
            for (int i = 0; i < NB; i++) begin
                if (m_s2[i] == m_st[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == int'(DC)) begin
                        m_st[i]  = m_s2[i];
                        m_run[i] = 0;
                        m_new[i] = m_s2[i];
                    end
                end
            end
            m_pend = m_new;
            m_s2   = m_s1;
            m_s1   = pressed;
        end
    end

    function automatic logic [31:0] ref_index(input logic [NB-1:0] v);
        for (int i = 0; i < NB; i++) if (v[i]) return 32'(i);
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_multi(input logic [NB-1:0] v);
        int n = 0;
        for (int i = 0; i < NB; i++) if (v[i]) n++;
        return (n > 1) ? 32'd1 : 32'd0;
    endfunction

    // Monitor: compare levels every cycle and pop one event per transfer.
    always @(negedge clk) begin
        logic [NB-1:0] e;
        if (!reset) begin
            check("held", 32'(held), 32'(m_st));
            check("press_valid", 32'(press_valid), 32'(m_valid));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (press_valid && press_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(press_onehot), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_onehot", 32'(press_onehot), 32'(e));
                    check("ev_index", 32'(press_index), ref_index(e));
                    check("ev_multi", 32'(press_multi), ref_multi(e));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  32'(press_valid),  32'd0);
        check({tag, "_onehot"}, 32'(press_onehot), 32'd0);
        check({tag, "_index"},  32'(press_index),  32'd0);
        check({tag, "_multi"},  32'(press_multi),  32'd0);
        check({tag, "_held"},   32'(held),         32'd0);
        check({tag, "_ovf"},    32'(overflow),     32'd0);
    endtask

    initial begin
        pressed     = '0;
        press_ready = 1'b1;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset = 1'b0;

        // Clean press of button 2.
        pressed[2] = 1'b1;
        step(6);
        check("s1_held", 32'(held), 32'h04);
        check("s1_valid_early", 32'(press_valid), 32'd0);
        step(1);
        check("s1_valid", 32'(press_valid), 32'd1);
        check("s1_onehot", 32'(press_onehot), 32'h04);
        check("s1_index", 32'(press_index), 32'd2);
        check("s1_multi", 32'(press_multi), 32'd0);
        step(1);
        check("s1_one_cycle", 32'(press_valid), 32'd0);
        pressed[2] = 1'b0;
        step(12);

        // Bouncing button 5, then settle high.
        for (int k = 0; k < 6; k++) begin
            pressed[5] = ~pressed[5];
            step(2);
        end
        pressed[5] = 1'b1;
        step(6);
        check("s2_valid_early", 32'(press_valid), 32'd0);
        check("s2_held", 32'(held), 32'h20);
        step(1);
        check("s2_valid", 32'(press_valid), 32'd1);
        check("s2_onehot", 32'(press_onehot), 32'h20);
        step(10);
        pressed[5] = 1'b0;
        step(10);

        // Simultaneous press of buttons 1 and 6.
        pressed[1] = 1'b1;
        pressed[6] = 1'b1;
        step(7);
        check("s3_onehot", 32'(press_onehot), 32'h42);
        check("s3_index", 32'(press_index), 32'd1);
        check("s3_multi", 32'(press_multi), 32'd1);
        step(10);
        pressed = '0;
        step(10);

        // Backpressure and overflow.
        press_ready = 1'b0;
        pressed[0]  = 1'b1;
        step(8);
        check("s4_valid", 32'(press_valid), 32'd1);
        pressed[3] = 1'b1;
        step(10);
        check("s4_ovf", 32'(overflow), 32'd1);
        check("s4_held_onehot", 32'(press_onehot), 32'h01);
        press_ready = 1'b1;
        step(1);
        check("s4_drained", 32'(press_valid), 32'd0);
        step(10);
        check("s4_no_second", 32'(press_valid), 32'd0);
        check("s4_ovf_sticky", 32'(overflow), 32'd1);
        pressed = '0;
        step(10);

        // Release of button 4 produces no event.
        pressed[4] = 1'b1;
        step(10);
        check("s5_held", 32'(held), 32'h10);
        pressed[4] = 1'b0;
        step(5);
        check("s5_held_still", 32'(held), 32'h10);
        step(1);
        check("s5_released", 32'(held), 32'h00);
        check("s5_no_event", 32'(press_valid), 32'd0);
        step(6);

        // Asynchronous reset in the middle of a debounce count.
        pressed[7] = 1'b1;
        step(3);
        #1 reset = 1'b1;
        #1;
        check_all_zero("s6_async");
        step(2);
        reset = 1'b0;
        step(6);
        check("s6_valid_early", 32'(press_valid), 32'd0);
        step(1);
        check("s6_valid", 32'(press_valid), 32'd1);
        check("s6_onehot", 32'(press_onehot), 32'h80);
        step(5);
        pressed = '0;
        step(10);

        // Random bouncing and random backpressure.
        repeat (3000) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 11) == 0) pressed[i] = ~pressed[i];
            press_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        press_ready = 1'b1;
        pressed     = '0;
        step(20);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
